// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, idle line level and bit-timing helpers.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic LINE_IDLE = 1'b1;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int half_bit(input int clk_freq, input int baud);
        return clks_per_bit(clk_freq, baud) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, parallel word and strobes out.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic [DATA_BITS-1:0] data;
    logic                 data_valid;
    logic                 frame_error;
    logic                 busy;

    modport master (input rx, output data, output data_valid, output frame_error, output busy);
    modport slave  (output rx, input data, input data_valid, input frame_error, input busy);
endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit; reset value selectable.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/uart_rx.sv
// UART receiver: start bit, DATA_BITS data bits LSB first, one stop bit; mid-bit sampling.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    uart_rx_if.master  bus
);
    localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
    localparam int HALF  = half_bit(CLK_FREQ, BAUD);
    localparam int CNT_W = $clog2(CPB);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 rxs;
    logic                 rxs_dly_q,  rxs_dly_d;
    uart_state_t          state_q,    state_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic [IDX_W-1:0]     idx_q,      idx_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic [DATA_BITS-1:0] data_q,     data_d;
    logic                 valid_q,    valid_d;
    logic                 ferr_q,     ferr_d;
    logic                 busy_q,     busy_d;

    sync_2ff #(.RST_VAL(LINE_IDLE)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.rx),
        .q     (rxs)
    );

    always_comb begin
        rxs_dly_d = rxs;
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // Arm only on a high-to-low edge so a held-low break line stays ignored.
                if (rxs_dly_q && !rxs) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxs ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                // Leave mid-stop-bit so a back-to-back start edge is still seen.
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rxs) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxs_dly_q <= LINE_IDLE;
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rxs_dly_q <= rxs_dly_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.data        = data_q;
    assign bus.data_valid  = valid_q;
    assign bus.frame_error = ferr_q;
    assign bus.busy        = busy_q;
endmodule
